hazard_scoreboard: RTL and testbench

Second-generation pipeline hazard unit for the 5-stage MIPS core; sits beside the ID stage and drives stall and flush controls for PC, IF/ID and ID/EX. It keeps the combinational load-use, branch-operand and control-hazard logic of the first-generation unit. It adds three things: per-operand usage qualifiers, a registered tracker for one multi-cycle multiply/divide unit (structural and RAW hazards), and saturating stall/flush performance counters.

---
 rtl/hazard_scoreboard_pkg.sv | 27 ++
 rtl/hazard_scoreboard_if.sv | 49 ++++
 rtl/hazard_scoreboard_md_tracker.sv | 76 +++++++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults, the MD tracker state type and a constant-width helper for the
// hazard scoreboard slice.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int MD_LATENCY_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard: ID/EX/MEM hazard inputs,
// stall/flush controls, MD tracker status and performance counters.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_md_start;
  logic [REG_ADDR_W-1:0] id_md_dst;
  logic                  ex_mem_read;
  logic                  ex_reg_write;
  logic [REG_ADDR_W-1:0] ex_write_reg;
  logic                  mem_mem_read;
  logic [REG_ADDR_W-1:0] mem_write_reg;
  logic                  reg_fwd;
  logic                  pc_update;
  logic                  overflow;

  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  if_id_flush;
  logic                  id_ex_stall;
  logic                  id_ex_flush;
  logic                  md_busy;
  logic                  md_done;
  logic [REG_ADDR_W-1:0] md_wb_reg;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start, id_md_dst,
           ex_mem_read, ex_reg_write, ex_write_reg, mem_mem_read, mem_write_reg,
           reg_fwd, pc_update, overflow,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           md_busy, md_done, md_wb_reg, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start, id_md_dst,
           ex_mem_read, ex_reg_write, ex_write_reg, mem_mem_read, mem_write_reg,
           reg_fwd, pc_update, overflow,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           md_busy, md_done, md_wb_reg, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_scoreboard_md_tracker.sv
// Occupancy tracker for the single multi-cycle multiply/divide unit.
//   state   | meaning
//   MD_IDLE | no MD op in flight
//   MD_BUSY | op in flight; md_cnt counts down to writeback (done at 1)
module md_tracker
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept_i,
  input  logic [REG_ADDR_W-1:0] md_dst_i,
  output logic                  md_busy_o,
  output logic                  md_done_o,
  output logic [REG_ADDR_W-1:0] md_wb_reg_o
);

  localparam int MD_CNT_W = clog2(MD_LATENCY + 1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic [REG_ADDR_W-1:0] md_wb_reg_q, md_wb_reg_d;
  logic                  md_done;

  assign md_done     = (state_q == MD_BUSY) && (md_cnt_q == MD_CNT_W'(1));
  assign md_busy_o   = (state_q == MD_BUSY);
  assign md_done_o   = md_done;
  assign md_wb_reg_o = md_wb_reg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MD_IDLE;
      md_cnt_q    <= '0;
      md_wb_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_wb_reg_q <= md_wb_reg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    md_wb_reg_d = md_wb_reg_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept_i) begin
          state_d     = MD_BUSY;
          md_cnt_d    = MD_CNT_W'(MD_LATENCY);
          md_wb_reg_d = md_dst_i;
        end
      end
      MD_BUSY: begin
        // An accept while busy can only happen in the done cycle (structural
        // hazard blocks it otherwise), so it is a back-to-back reissue.
        if (accept_i) begin
          md_cnt_d    = MD_CNT_W'(MD_LATENCY);
          md_wb_reg_d = md_dst_i;
        end else if (md_done) begin
          state_d  = MD_IDLE;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d  = MD_IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use, branch-operand, MD RAW/structural and control
// hazards driving stall/flush controls, plus saturating stall/flush counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  hazard_scoreboard_if.slave hz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                  md_busy;
  logic                  md_done;
  logic [REG_ADDR_W-1:0] md_wb_reg;
  logic                  md_accept;

  logic                  load_hazard;
  logic                  ex_reg_hazard;
  logic                  mem_reg_hazard;
  logic                  md_raw;
  logic                  md_struct;
  logic                  data_hazard;
  logic                  control_hazard;
  logic                  flush_event;

  logic [CNT_W-1:0]      stall_count_q, stall_count_d;
  logic [CNT_W-1:0]      flush_count_q, flush_count_d;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] dst,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt,
                                     input logic                  uses_rs,
                                     input logic                  uses_rt);
    return (dst != '0) && ((uses_rs && (rs == dst)) || (uses_rt && (rt == dst)));
  endfunction

  assign load_hazard    = hz.ex_mem_read &&
                          src_match(hz.ex_write_reg, hz.id_rs, hz.id_rt,
                                    hz.id_uses_rs, hz.id_uses_rt);
  assign ex_reg_hazard  = hz.reg_fwd && hz.ex_reg_write &&
                          src_match(hz.ex_write_reg, hz.id_rs, hz.id_rt,
                                    hz.id_uses_rs, hz.id_uses_rt);
  assign mem_reg_hazard = hz.reg_fwd && hz.mem_mem_read &&
                          src_match(hz.mem_write_reg, hz.id_rs, hz.id_rt,
                                    hz.id_uses_rs, hz.id_uses_rt);
  // Still asserted in the writeback cycle; conservative by one cycle.
  assign md_raw         = md_busy &&
                          src_match(md_wb_reg, hz.id_rs, hz.id_rt,
                                    hz.id_uses_rs, hz.id_uses_rt);
  assign md_struct      = hz.id_md_start && md_busy && !md_done;

  assign data_hazard    = load_hazard || ex_reg_hazard || mem_reg_hazard ||
                          md_raw || md_struct;
  assign control_hazard = hz.pc_update || hz.overflow;
  assign md_accept      = hz.id_md_start && !data_hazard && !hz.overflow;

  assign hz.pc_stall    = data_hazard;
  assign hz.if_id_stall = data_hazard;
  assign hz.id_ex_flush = data_hazard;
  assign hz.if_id_flush = control_hazard && !data_hazard;
  assign hz.id_ex_stall = 1'b0;

  assign hz.md_busy     = md_busy;
  assign hz.md_done     = md_done;
  assign hz.md_wb_reg   = md_wb_reg;

  md_tracker #(
    .REG_ADDR_W (REG_ADDR_W),
    .MD_LATENCY (MD_LATENCY)
  ) u_md_tracker (
    .clk         (clk),
    .reset       (reset),
    .accept_i    (md_accept),
    .md_dst_i    (hz.id_md_dst),
    .md_busy_o   (md_busy),
    .md_done_o   (md_done),
    .md_wb_reg_o (md_wb_reg)
  );

  assign flush_event = hz.if_id_flush || hz.id_ex_flush;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (data_hazard && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (flush_event && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic against a cycle-indexed reference model.
module tb_hazard_scoreboard;

  localparam int RW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_scoreboard_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  hazard_scoreboard #(
    .REG_ADDR_W (RW),
    .MD_LATENCY (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an MD op issued in cycle issue_cyc is busy in
  // issue_cyc+1 .. issue_cyc+LAT and completes in issue_cyc+LAT.
  int          cyc;
  int          issue_cyc;
  logic [RW-1:0] m_wb;
  int          m_stall;
  int          m_flush;

  function automatic logic m_busy();
    return (issue_cyc >= 0) && (cyc > issue_cyc) && (cyc <= issue_cyc + LAT);
  endfunction

  function automatic logic m_done();
    return (issue_cyc >= 0) && (cyc == issue_cyc + LAT);
  endfunction

  function automatic logic m_match(input logic [RW-1:0] r);
    return (r != 0) && ((bus.id_uses_rs && bus.id_rs == r) ||
                        (bus.id_uses_rt && bus.id_rt == r));
  endfunction

  function automatic logic m_data();
    return (bus.ex_mem_read && m_match(bus.ex_write_reg)) ||
           (bus.reg_fwd && bus.ex_reg_write && m_match(bus.ex_write_reg)) ||
           (bus.reg_fwd && bus.mem_mem_read && m_match(bus.mem_write_reg)) ||
           (m_busy() && m_match(m_wb)) ||
           (bus.id_md_start && m_busy() && !m_done());
  endfunction

  function automatic logic [19:0] exp_vec();
    logic d, c;
    d = m_data();
    c = bus.pc_update || bus.overflow;
    return {d, d, c && !d, 1'b0, d, m_busy(), m_done(), m_wb,
            CW'(m_stall), CW'(m_flush)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
            bus.id_ex_flush, bus.md_busy, bus.md_done, bus.md_wb_reg,
            bus.stall_count, bus.flush_count};
  endfunction

  task automatic tick();
    logic d, c;
    d = m_data();
    c = bus.pc_update || bus.overflow;
    if (reset) begin
      issue_cyc = -1;
      m_wb      = '0;
      m_stall   = 0;
      m_flush   = 0;
    end else begin
      if (bus.id_md_start && !d && !bus.overflow) begin
        issue_cyc = cyc;
        m_wb      = bus.id_md_dst;
      end
      if (d && m_stall < CMAX) m_stall++;
      if ((d || c) && m_flush < CMAX) m_flush++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs = '0;  bus.id_rt = '0;
    bus.id_uses_rs = 1'b0;  bus.id_uses_rt = 1'b0;
    bus.id_md_start = 1'b0;  bus.id_md_dst = '0;
    bus.ex_mem_read = 1'b0;  bus.ex_reg_write = 1'b0;  bus.ex_write_reg = '0;
    bus.mem_mem_read = 1'b0;  bus.mem_write_reg = '0;
    bus.reg_fwd = 1'b0;  bus.pc_update = 1'b0;  bus.overflow = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    #1;
    checks++;
    if ({bus.md_busy, bus.md_done, bus.md_wb_reg} !== 7'b0) begin
      errors++;
      $display("FAIL reset_md: got busy=%0b done=%0b wb=%0d want 0 0 0",
               bus.md_busy, bus.md_done, bus.md_wb_reg);
    end
    checks++;
    if ({bus.stall_count, bus.flush_count} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0 0",
               bus.stall_count, bus.flush_count);
    end
    checks++;
    if ({bus.pc_stall, bus.if_id_flush, bus.id_ex_stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000",
               {bus.pc_stall, bus.if_id_flush, bus.id_ex_stall});
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.ex_mem_read = 1'b1;  bus.ex_write_reg = 5'd8;
    bus.id_rs = 5'd8;  bus.id_uses_rs = 1'b1;
    #1;
    checks++;
    if ({bus.pc_stall, bus.if_id_stall, bus.id_ex_flush} !== 3'b111) begin
      errors++;
      $display("FAIL load_use: got %b want 111",
               {bus.pc_stall, bus.if_id_stall, bus.id_ex_flush});
    end
    bus.id_uses_rs = 1'b0;
    #1;
    checks++;
    if ({bus.pc_stall, bus.if_id_stall, bus.id_ex_flush} !== 3'b000) begin
      errors++;
      $display("FAIL load_use_unused: got %b want 000",
               {bus.pc_stall, bus.if_id_stall, bus.id_ex_flush});
    end
    bus.id_uses_rs = 1'b1;  bus.id_rs = 5'd0;  bus.ex_write_reg = 5'd0;
    #1;
    checks++;
    if (bus.pc_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_r0: got %b want 0", bus.pc_stall);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_mem_load();
    clear_inputs();
    bus.reg_fwd = 1'b1;  bus.mem_mem_read = 1'b1;  bus.mem_write_reg = 5'd9;
    bus.id_rt = 5'd9;  bus.id_uses_rt = 1'b1;
    #1;
    checks++;
    if (bus.pc_stall !== 1'b1) begin
      errors++;
      $display("FAIL branch_mem_load: got %b want 1", bus.pc_stall);
    end
    bus.pc_update = 1'b1;
    #1;
    checks++;
    if ({bus.if_id_flush, bus.id_ex_flush} !== 2'b01) begin
      errors++;
      $display("FAIL branch_stall_wins: got %b want 01",
               {bus.if_id_flush, bus.id_ex_flush});
    end
    tick();
    clear_inputs();
    bus.pc_update = 1'b1;
    #1;
    checks++;
    if (bus.if_id_flush !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_flush: got %b want 1", bus.if_id_flush);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if ({bus.stall_count, bus.flush_count} !== {CW'(m_stall), CW'(m_flush)}) begin
      errors++;
      $display("FAIL branch_counts: got stall=%0d flush=%0d want %0d %0d",
               bus.stall_count, bus.flush_count, m_stall, m_flush);
    end
  endtask

  task automatic test_md_issue();
    clear_inputs();
    bus.id_md_start = 1'b1;  bus.id_md_dst = 5'd10;
    tick();
    bus.id_md_start = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      bus.id_rs = 5'd10;  bus.id_uses_rs = 1'b1;
      #1;
      checks++;
      if ({bus.md_busy, bus.md_done, bus.md_wb_reg, bus.pc_stall} !==
          {1'b1, (k == LAT), 5'd10, 1'b1}) begin
        errors++;
        $display("FAIL md_issue c%0d: got busy=%0b done=%0b wb=%0d stall=%0b want 1 %0b 10 1",
                 k, bus.md_busy, bus.md_done, bus.md_wb_reg, bus.pc_stall, (k == LAT));
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if ({bus.md_busy, bus.md_done} !== 2'b00) begin
      errors++;
      $display("FAIL md_issue_end: got busy=%0b done=%0b want 0 0",
               bus.md_busy, bus.md_done);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    bus.id_md_start = 1'b1;  bus.id_md_dst = 5'd11;
    tick();
    bus.id_md_start = 1'b0;
    tick();
    bus.id_md_start = 1'b1;  bus.id_md_dst = 5'd12;
    for (int k = 2; k <= LAT; k++) begin
      #1;
      checks++;
      if (bus.pc_stall !== (k != LAT)) begin
        errors++;
        $display("FAIL b2b_struct c%0d: got %b want %b", k, bus.pc_stall, (k != LAT));
      end
      tick();
    end
    bus.id_md_start = 1'b0;
    for (int k = LAT + 1; k <= 2 * LAT + 1; k++) begin
      #1;
      checks++;
      if ({bus.md_busy, bus.md_wb_reg} !== {(k <= 2 * LAT), 5'd12}) begin
        errors++;
        $display("FAIL b2b_busy c%0d: got busy=%0b wb=%0d want %0b 12",
                 k, bus.md_busy, bus.md_wb_reg, (k <= 2 * LAT));
      end
      tick();
    end
  endtask

  task automatic test_overflow_and_reset();
    clear_inputs();
    bus.id_md_start = 1'b1;  bus.id_md_dst = 5'd13;  bus.overflow = 1'b1;
    #1;
    checks++;
    if ({bus.if_id_flush, bus.pc_stall} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_ctrl: got %b want 10", {bus.if_id_flush, bus.pc_stall});
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.md_busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_no_accept: got busy=%0b want 0", bus.md_busy);
    end
    bus.id_md_start = 1'b1;  bus.id_md_dst = 5'd14;
    tick();
    bus.id_md_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      #1;
      checks++;
      if ({bus.md_busy, bus.md_done} !== 2'b00) begin
        errors++;
        $display("FAIL reset_abandon c%0d: got busy=%0b done=%0b want 0 0",
                 k, bus.md_busy, bus.md_done);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    do_reset();
    bus.ex_mem_read = 1'b1;  bus.ex_write_reg = 5'd3;
    bus.id_rt = 5'd3;  bus.id_uses_rt = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    #1;
    checks++;
    if ({bus.stall_count, bus.flush_count} !== {CW'(CMAX), CW'(CMAX)}) begin
      errors++;
      $display("FAIL saturate: got stall=%0d flush=%0d want %0d %0d",
               bus.stall_count, bus.flush_count, CMAX, CMAX);
    end
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.stall_count, bus.flush_count} !== '0) begin
      errors++;
      $display("FAIL sat_reset: got stall=%0d flush=%0d want 0 0",
               bus.stall_count, bus.flush_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset            = ($urandom_range(0, 60) == 0);
      bus.id_rs        = RW'($urandom_range(0, 4));
      bus.id_rt        = RW'($urandom_range(0, 4));
      bus.id_uses_rs   = 1'($urandom_range(0, 1));
      bus.id_uses_rt   = 1'($urandom_range(0, 1));
      bus.id_md_start  = ($urandom_range(0, 2) == 0);
      bus.id_md_dst    = RW'($urandom_range(0, 4));
      bus.ex_mem_read  = ($urandom_range(0, 3) == 0);
      bus.ex_reg_write = 1'($urandom_range(0, 1));
      bus.ex_write_reg = RW'($urandom_range(0, 4));
      bus.mem_mem_read = ($urandom_range(0, 3) == 0);
      bus.mem_write_reg = RW'($urandom_range(0, 4));
      bus.reg_fwd      = ($urandom_range(0, 2) == 0);
      bus.pc_update    = ($urandom_range(0, 4) == 0);
      bus.overflow     = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random c%0d: got %b want %b", n, dut_vec(), exp_vec());
      end
      tick();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    issue_cyc = -1;
    m_wb      = '0;
    m_stall   = 0;
    m_flush   = 0;
    reset     = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_branch_mem_load();
    test_md_issue();
    test_back_to_back();
    test_overflow_and_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
